arcade_input: RTL and testbench

ARCADE_INPUT -- requirements
Module: arcade_input

---
 rtl/arcade_input.sv | 146 ++++++++++++++
 tb/tb_arcade_input.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/arcade_input.sv
// arcade_input: merges PS/2 keyboard events and two joysticks into registered
// per-player arcade controls, with optional SOCD neutralising and timed coin pulses.
module arcade_input #(
    parameter logic [23:0] COIN_HOLD    = 24'd1_000_000,
    parameter logic        SOCD_NEUTRAL = 1'b1
) (
    input  logic        clk_sys,
    input  logic        RESET,
    input  logic [10:0] ps2_key,
    input  logic [31:0] joystick_0,
    input  logic [31:0] joystick_1,
    output logic [3:0]  p1_dir,
    output logic [3:0]  p2_dir,
    output logic [2:0]  p1_buttons,
    output logic [2:0]  p2_buttons,
    output logic        p1_start,
    output logic        p2_start,
    output logic        p1_coin,
    output logic        p2_coin,
    output logic        p1_pause,
    output logic        p2_pause,
    output logic        service_1,
    output logic        service_2
);
    typedef enum logic {IDLE, PULSE} coin_st_t;

    // Bit order keeps each group aligned with its output: [3:0] P1 {up,down,left,right},
    // [6:4] P1 {b3,b2,b1}, [16:13] P2 dirs, [19:17] P2 buttons.
    function automatic logic [20:0] key_hit(input logic [7:0] c);
        key_hit = '0;
        case (c)
            8'h74: key_hit[0]  = 1'b1;
            8'h6B: key_hit[1]  = 1'b1;
            8'h72: key_hit[2]  = 1'b1;
            8'h75: key_hit[3]  = 1'b1;
            8'h14: key_hit[4]  = 1'b1;
            8'h11: key_hit[5]  = 1'b1;
            8'h29: key_hit[6]  = 1'b1;
            8'h16: key_hit[7]  = 1'b1;
            8'h1E: key_hit[8]  = 1'b1;
            8'h2E: key_hit[9]  = 1'b1;
            8'h36: key_hit[10] = 1'b1;
            8'h46: key_hit[11] = 1'b1;
            8'h45: key_hit[12] = 1'b1;
            8'h34: key_hit[13] = 1'b1;
            8'h23: key_hit[14] = 1'b1;
            8'h2B: key_hit[15] = 1'b1;
            8'h2D: key_hit[16] = 1'b1;
            8'h1C: key_hit[17] = 1'b1;
            8'h1B: key_hit[18] = 1'b1;
            8'h15: key_hit[19] = 1'b1;
            8'h4D: key_hit[20] = 1'b1;
            default: key_hit = '0;
        endcase
    endfunction

    function automatic logic [3:0] socd(input logic [3:0] d);
        logic ud, lr;
        ud = SOCD_NEUTRAL & d[3] & d[2];
        lr = SOCD_NEUTRAL & d[1] & d[0];
        socd = d & ~{ud, ud, lr, lr};
    endfunction

    logic [20:0] keys_q, keys_d, hit;
    logic        tog_q, tog_d, init_q, init_d;
    logic [21:0] out_q, out_d;
    coin_st_t    st_q [2];
    coin_st_t    st_d [2];
    logic [23:0] cnt_q [2];
    logic [23:0] cnt_d [2];
    logic [1:0]  prev_q, prev_d, coin_q, coin_d, coin_raw;
    logic        unused;

    assign unused = ^{ps2_key[8], joystick_0[31:11], joystick_1[31:11]};
    assign coin_raw = {keys_q[10] | joystick_1[8], keys_q[9] | joystick_0[8]};

    always_comb begin
        hit    = key_hit(ps2_key[7:0]);
        tog_d  = ps2_key[10];
        init_d = 1'b1;
        keys_d = (init_q && ps2_key[10] != tog_q) ? (ps2_key[9] ? keys_q | hit : keys_q & ~hit) : keys_q;
        out_d  = {socd(keys_q[3:0] | joystick_0[3:0]),
                  socd(keys_q[16:13] | joystick_1[3:0]),
                  keys_q[6:4] | joystick_0[6:4],
                  keys_q[19:17] | joystick_1[6:4],
                  keys_q[7] | joystick_0[7],
                  keys_q[8] | joystick_1[7],
                  keys_q[20] | joystick_0[9],
                  joystick_1[9],
                  keys_q[11] | joystick_0[10],
                  keys_q[12] | joystick_1[10]};
    end

    // Coin triggers are blocked on the first edge so a coin held through reset never fires.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            st_d[p]   = st_q[p];
            cnt_d[p]  = cnt_q[p];
            coin_d[p] = coin_q[p];
            prev_d[p] = coin_raw[p];
            if (st_q[p] == IDLE) begin
                if (init_q && coin_raw[p] && !prev_q[p]) begin
                    st_d[p]   = PULSE;
                    cnt_d[p]  = COIN_HOLD - 24'd1;
                    coin_d[p] = 1'b1;
                end
            end else if (cnt_q[p] == '0) begin
                st_d[p]   = IDLE;
                coin_d[p] = 1'b0;
            end else begin
                cnt_d[p] = cnt_q[p] - 24'd1;
            end
        end
    end

    always_ff @(posedge clk_sys or posedge RESET) begin
        if (RESET) begin
            keys_q <= '0;
            tog_q  <= 1'b0;
            init_q <= 1'b0;
            out_q  <= '0;
            prev_q <= '0;
            coin_q <= '0;
            for (int p = 0; p < 2; p++) begin
                st_q[p]  <= IDLE;
                cnt_q[p] <= '0;
            end
        end else begin
            keys_q <= keys_d;
            tog_q  <= tog_d;
            init_q <= init_d;
            out_q  <= out_d;
            prev_q <= prev_d;
            coin_q <= coin_d;
            for (int p = 0; p < 2; p++) begin
                st_q[p]  <= st_d[p];
                cnt_q[p] <= cnt_d[p];
            end
        end
    end

    assign {p1_dir, p2_dir, p1_buttons, p2_buttons, p1_start, p2_start,
            p1_pause, p2_pause, service_1, service_2} = out_q;
    assign p1_coin = coin_q[0];
    assign p2_coin = coin_q[1];
endmodule

// File: tb/tb_arcade_input.sv
// tb_arcade_input: directed scoreboard bench for arcade_input; expectations are queued
// when stimulus is driven and popped when the outputs are sampled.
module tb_arcade_input;
    logic        clk_sys = 1'b0;
    logic        RESET = 1'b1;
    logic [10:0] ps2_key = '0;
    logic [31:0] joystick_0 = '0, joystick_1 = '0;
    logic [3:0]  p1_dir, p2_dir, n_p1_dir, n_p2_dir;
    logic [2:0]  p1_buttons, p2_buttons, n_p1_buttons, n_p2_buttons;
    logic        p1_start, p2_start, p1_coin, p2_coin, p1_pause, p2_pause, service_1, service_2;
    logic        n_p1_start, n_p2_start, n_p1_coin, n_p2_coin, n_p1_pause, n_p2_pause, n_service_1, n_service_2;
    logic [21:0] all_out;

    typedef struct {
        string       tag;
        logic [31:0] v;
    } exp_t;

    exp_t sb[$];
    int   total = 0, passed = 0, fails = 0;
    logic tog = 1'b0;
    logic [5:0] raw_seq, exp_seq;

    always #5 clk_sys = ~clk_sys;

    assign all_out = {p1_dir, p2_dir, p1_buttons, p2_buttons, p1_start, p2_start,
                      p1_coin, p2_coin, p1_pause, p2_pause, service_1, service_2};

    arcade_input #(.COIN_HOLD(24'd4), .SOCD_NEUTRAL(1'b1)) dut (
        .clk_sys(clk_sys), .RESET(RESET), .ps2_key(ps2_key),
        .joystick_0(joystick_0), .joystick_1(joystick_1),
        .p1_dir(p1_dir), .p2_dir(p2_dir), .p1_buttons(p1_buttons), .p2_buttons(p2_buttons),
        .p1_start(p1_start), .p2_start(p2_start), .p1_coin(p1_coin), .p2_coin(p2_coin),
        .p1_pause(p1_pause), .p2_pause(p2_pause), .service_1(service_1), .service_2(service_2)
    );

    arcade_input #(.COIN_HOLD(24'd4), .SOCD_NEUTRAL(1'b0)) dut_n (
        .clk_sys(clk_sys), .RESET(RESET), .ps2_key(ps2_key),
        .joystick_0(joystick_0), .joystick_1(joystick_1),
        .p1_dir(n_p1_dir), .p2_dir(n_p2_dir), .p1_buttons(n_p1_buttons), .p2_buttons(n_p2_buttons),
        .p1_start(n_p1_start), .p2_start(n_p2_start), .p1_coin(n_p1_coin), .p2_coin(n_p2_coin),
        .p1_pause(n_p1_pause), .p2_pause(n_p2_pause), .service_1(n_service_1), .service_2(n_service_2)
    );

    task automatic tick(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic push(input string tag, input logic [31:0] v);
        sb.push_back('{tag, v});
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        total++;
        if (sb.size() == 0) begin
            fails++;
            $error("FAIL scoreboard_empty observed=%h expected=none", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.v) passed++;
            else begin
                fails++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.v);
            end
        end
    endtask

    task automatic key(input logic press, input logic ext, input logic [7:0] code);
        tog = ~tog;
        ps2_key = {tog, press, ext, code};
    endtask

    initial begin
        tick(2);
        push("reset_all", 0); check(32'(all_out));
        RESET = 1'b0;
        tick(1);

        key(1'b1, 1'b0, 8'h75);
        push("kb_up_lat1", 0); push("kb_up", 32'h8);
        tick(1); check(32'(p1_dir));
        tick(1); check(32'(p1_dir));
        key(1'b0, 1'b0, 8'h75); push("kb_up_release", 0);
        tick(2); check(32'(p1_dir));
        key(1'b1, 1'b1, 8'h75); push("kb_ext_up", 32'h8);
        tick(2); check(32'(p1_dir));
        key(1'b0, 1'b1, 8'h75); push("kb_ext_release", 0);
        tick(2); check(32'(p1_dir));
        key(1'b1, 1'b0, 8'h5A); push("kb_unmapped", 0);
        tick(2); check(32'(all_out));

        key(1'b1, 1'b0, 8'h2D); tick(1);
        key(1'b1, 1'b0, 8'h34); push("kb_p2_rg", 32'h9);
        tick(2); check(32'(p2_dir));
        key(1'b1, 1'b0, 8'h2B); push("kb_p2_socd", 32'h1); push("kb_p2_nosocd", 32'hD);
        tick(2); check(32'(p2_dir)); check(32'(n_p2_dir));
        key(1'b0, 1'b0, 8'h2D); tick(1);
        key(1'b0, 1'b0, 8'h2B); tick(1);
        key(1'b0, 1'b0, 8'h34); push("kb_p2_clear", 0);
        tick(2); check(32'(p2_dir));

        key(1'b1, 1'b0, 8'h29); push("kb_space", 32'h4);
        tick(2); check(32'(p1_buttons));
        joystick_0 = 32'h10; push("joy_btn_merge", 32'h5);
        tick(1); check(32'(p1_buttons));
        joystick_0 = '0; key(1'b0, 1'b0, 8'h29); push("btn_clear", 0);
        tick(2); check(32'(p1_buttons));
        key(1'b1, 1'b0, 8'h16); push("kb_p1_start", 1);
        tick(2); check(32'(p1_start));
        key(1'b0, 1'b0, 8'h16); tick(2);
        key(1'b1, 1'b0, 8'h15); push("kb_p2_b3", 32'h4);
        tick(2); check(32'(p2_buttons));
        key(1'b0, 1'b0, 8'h15); tick(2);

        key(1'b1, 1'b0, 8'h36); push("kb_p2_coin_lat1", 0); push("kb_p2_coin", 1);
        tick(1); check(32'(p2_coin));
        tick(1); check(32'(p2_coin));
        key(1'b0, 1'b0, 8'h36); tick(8);

        joystick_0 = 32'h0C; push("joy_socd_ud", 0); push("joy_nosocd_ud", 32'hC);
        tick(1); check(32'(p1_dir)); check(32'(n_p1_dir));
        joystick_0 = 32'h09; push("joy_9", 32'h9); push("joy_9_n", 32'h9);
        tick(1); check(32'(p1_dir)); check(32'(n_p1_dir));
        joystick_0 = 32'h03; push("joy_socd_lr", 0); push("joy_nosocd_lr", 32'h3);
        tick(1); check(32'(p1_dir)); check(32'(n_p1_dir));
        joystick_0 = '0;
        joystick_1 = 32'h200; push("joy_p2_pause", 1);
        tick(1); check(32'(p2_pause));
        joystick_1 = '0; tick(2);

        joystick_0 = 32'h100;
        for (int i = 0; i < 20; i++) begin
            push($sformatf("coin_hold_c%0d", i), (i < 4) ? 1 : 0);
            tick(1); check(32'(p1_coin));
        end
        joystick_0 = '0; tick(2);

        raw_seq = 6'b111101; exp_seq = 6'b001111;
        for (int i = 0; i < 6; i++) begin
            joystick_0[8] = raw_seq[i];
            push($sformatf("coin_rerise_c%0d", i), 32'(exp_seq[i]));
            tick(1); check(32'(p1_coin));
        end
        joystick_0 = '0; tick(2);

        raw_seq = 6'b110001;
        for (int i = 0; i < 6; i++) begin
            joystick_0[8] = raw_seq[i];
            push($sformatf("coin_end_edge_c%0d", i), 32'(exp_seq[i]));
            tick(1); check(32'(p1_coin));
        end
        joystick_0 = '0; tick(2);

        joystick_0 = 32'h100; tick(1);
        push("rst_pulse_c2", 1); tick(1); check(32'(p1_coin));
        #2 RESET = 1'b1;
        tog = 1'b1; ps2_key = {1'b1, 1'b1, 1'b0, 8'h75};
        #1 push("rst_async", 0); check(32'(p1_coin));
        tick(2);
        push("rst_hold_all", 0); check(32'(all_out));
        RESET = 1'b0;
        for (int i = 0; i < 6; i++) begin
            push($sformatf("rst_coin_held_c%0d", i), 0);
            tick(1); check(32'(p1_coin));
        end
        push("pwr_toggle_ignored", 0); check(32'(p1_dir));
        joystick_0 = '0; tick(1);
        joystick_0 = 32'h100; push("coin_rearm", 1);
        tick(1); check(32'(p1_coin));
        key(1'b1, 1'b0, 8'h75); push("pwr_decode", 32'h8);
        tick(2); check(32'(p1_dir));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
